// File: rtl/bcd_serial.sv
// Sequential binary-to-BCD converter (shift-and-add-3). Captures a binary
// value on start, runs SIZE shift steps, then publishes packed BCD digits
// with a one-cycle done pulse and a sticky overflow flag.

// Per-digit adjust: a nibble of 5..9 gets +3 so the following left shift
// carries correctly into the next decimal digit. Inputs never exceed 9, so
// the result stays within the nibble.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module bcd_serial #(
  parameter int SIZE   = 8,   // must be >= 2
  parameter int DIGITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SIZE-1:0]     binary,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                overflow,
  output logic [1:0]          curr_state
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [SIZE-1:0] sr;
  logic [W-1:0]    acc;
  logic [W-1:0]    adj;
  logic [CW-1:0]   cnt;
  logic            ovf;

  // All digits adjusted in parallel from the pre-shift accumulator.
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      bcd_add3 u_add3 (
        .din  (acc[4*g +: 4]),
        .dout (adj[4*g +: 4])
      );
    end
  endgenerate

  assign curr_state = state;

  // Control FSM plus datapath: load, SIZE shift steps, then publish results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      sr       <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr    <= binary;
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= CW'(SIZE);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // {acc,sr} shifts left one bit; the adjusted top bit falls out
          // into the sticky overflow flag.
          acc <= {adj[W-2:0], sr[SIZE-1]};
          sr  <= {sr[SIZE-2:0], 1'b0};
          ovf <= ovf | adj[W-1];
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE: begin
          bcd_out  <= acc;
          overflow <= ovf;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_serial.sv
// Scoreboard bench for bcd_serial. Two instances share stimulus: an 8-digit
// one (no overflow possible) and a 2-digit one (exercises overflow). A
// reference model decides acceptance from throughput rules and computes the
// decimal digits with plain arithmetic; monitors compare on every done.
module tb_bcd_serial;
  localparam int SIZE = 8;
  localparam int LAT  = SIZE + 1;   // edges from acceptance to done
  localparam int PER  = SIZE + 2;   // edges between acceptances

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
    int          due;
  } exp_t;

  logic            clk, rst, start;
  logic [SIZE-1:0] binary;
  logic            busy8, done8, ovf8, busy2, done2, ovf2;
  logic [31:0]     bcd8;
  logic [7:0]      bcd2;
  logic [1:0]      st8, st2;

  int   checks = 0, errors = 0;
  int   cyc = 0, next_ok = 0;
  exp_t q8[$], q2[$];
  exp_t e8, e2;
  logic [31:0] last8;

  bcd_serial #(.SIZE(SIZE), .DIGITS(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .binary(binary),
    .busy(busy8), .done(done8), .bcd_out(bcd8), .overflow(ovf8),
    .curr_state(st8)
  );

  bcd_serial #(.SIZE(SIZE), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .binary(binary),
    .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2),
    .curr_state(st2)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Decimal digits by repeated division; overflow if anything is left over.
  function automatic logic [32:0] model(input int unsigned v, input int nd);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < nd; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return {v != 0, b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one acceptance per PER edges, reset aborts everything.
  always @(posedge clk) begin
    logic [32:0] m;
    cyc++;
    if (rst) begin
      q8.delete();
      q2.delete();
      next_ok = cyc + 1;
    end else if (start && cyc >= next_ok) begin
      m = model(binary, 8);
      q8.push_back('{m[31:0], m[32], cyc + LAT});
      m = model(binary, 2);
      q2.push_back('{m[31:0], m[32], cyc + LAT});
      next_ok = cyc + PER;
    end
  end

  // Monitor for the 8-digit instance.
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) chk("done8_unexpected", 32'(done8), 32'd0);
      else begin
        e8 = q8.pop_front();
        chk("lat8", cyc, e8.due);
        chk("bcd8", bcd8, e8.bcd);
        chk("ovf8", 32'(ovf8), 32'(e8.ovf));
        last8 = e8.bcd;
      end
    end else if (q8.size() > 0 && cyc >= q8[0].due) begin
      chk("done8_missing", 32'(done8), 32'd1);
      void'(q8.pop_front());
    end
  end

  // Monitor for the 2-digit instance.
  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) chk("done2_unexpected", 32'(done2), 32'd0);
      else begin
        e2 = q2.pop_front();
        chk("lat2", cyc, e2.due);
        chk("bcd2", 32'(bcd2), e2.bcd);
        chk("ovf2", 32'(ovf2), 32'(e2.ovf));
      end
    end else if (q2.size() > 0 && cyc >= q2[0].due) begin
      chk("done2_missing", 32'(done2), 32'd1);
      void'(q2.pop_front());
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (cyc + 1 < next_ok && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One start pulse; binary is scrambled right after to prove it is only
  // sampled at acceptance. Checks the SHIFT state is entered.
  task automatic conv(input int v);
    wait_ready();
    start  = 1'b1;
    binary = SIZE'(v);
    @(negedge clk);
    start  = 1'b0;
    binary = SIZE'($urandom);
    chk("state_shift", 32'(st8), 32'd1);
    chk("busy_shift", 32'(busy8), 32'd1);
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_state"}, 32'(st8), 32'd0);
    chk({tag, "_busy"}, 32'(busy8), 32'd0);
    chk({tag, "_done"}, 32'(done8), 32'd0);
    chk({tag, "_bcd8"}, bcd8, 32'd0);
    chk({tag, "_ovf8"}, 32'(ovf8), 32'd0);
    chk({tag, "_bcd2"}, 32'(bcd2), 32'd0);
    chk({tag, "_st2"}, 32'(st2), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; binary = '0;
    repeat (3) @(negedge clk);
    idle_checks("reset");
    rst = 1'b0;

    // Directed values, including boundaries and overflow on the 2-digit unit.
    conv(120);
    conv(0);
    conv(255);
    conv(9);
    conv(10);
    conv(99);

    // Start during SHIFT must be dropped, then a real request is taken.
    conv(120);
    repeat (2) @(negedge clk);
    start = 1'b1; binary = 8'd7;
    @(negedge clk);
    start = 1'b0;
    conv(7);

    // Held start: back-to-back conversions with binary changing every cycle.
    wait_ready();
    start = 1'b1;
    repeat (32) begin
      binary = SIZE'($urandom);
      @(negedge clk);
    end
    start = 1'b0;

    // Outputs hold between conversions.
    repeat (15) @(negedge clk);
    chk("hold_bcd8", bcd8, last8);

    // Reset mid-conversion aborts and clears outputs; no done must follow.
    conv(200);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_checks("midrst");
    repeat (12) @(negedge clk);
    chk("midrst_hold_bcd8", bcd8, 32'd0);

    // Random values with random gaps and stray start pulses.
    for (int i = 0; i < 40; i++) begin
      conv($urandom_range(0, 255));
      repeat ($urandom_range(0, 12)) begin
        start = ($urandom_range(0, 3) == 0);
        binary = SIZE'($urandom);
        @(negedge clk);
      end
      start = 1'b0;
    end

    n = 0;
    while ((q8.size() != 0 || q2.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q8.size() + q2.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
